// File: rtl/key_digit_editor_if.sv
// rtl/key_digit_editor_if.sv - board-side key/switch inputs and edited value outputs of key_digit_editor
interface key_digit_editor_if;
   logic [3:0]  Key;
   logic [7:0]  Sw;
   logic [31:0] Value;
   logic [2:0]  Cursor;
   logic        Changed;
   logic [3:0]  KeyState;

   modport master (output Key, Sw, input Value, Cursor, Changed, KeyState);
   modport slave  (input Key, Sw, output Value, Cursor, Changed, KeyState);
endinterface

// File: rtl/key_digit_editor.sv
// rtl/key_digit_editor.sv - debounced key/switch editor for a 32-bit hex value with digit cursor
module key_digit_editor #(
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter int          REPEAT_DELAY    = 25000000,
   parameter int          REPEAT_PERIOD   = 5000000,
   parameter logic [31:0] INIT_VALUE      = 32'h00000000
) (
   input logic            clk,
   input logic            rst,
   key_digit_editor_if.slave bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(REPEAT_DELAY + 1);
   localparam int PW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;

   logic [3:0]    key_s1, key_s2;
   logic [7:0]    sw_s1, sw_s2;
   logic [3:0]    key_state, key_state_d;
   logic [DW-1:0] db_cnt [4];
   logic [HW-1:0] hold_cnt [2];
   logic [PW-1:0] rep_cnt [2];
   logic [3:0]    press, ev;
   logic [1:0]    rep;
   logic [31:0]   value, inc_val, dec_val, load_val, step;
   logic [2:0]    cursor;
   logic          changed;
   logic [4:0]    lsb;
   logic [3:0]    nib;
   logic          unused_sw;

   assign bus.Value    = value;
   assign bus.Cursor   = cursor;
   assign bus.Changed  = changed;
   assign bus.KeyState = key_state;
   assign unused_sw    = ^sw_s2[5:4];

   always_ff @(posedge clk) begin
      if (rst) begin
         key_s1 <= '1;
         key_s2 <= '1;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         key_s1 <= bus.Key;
         key_s2 <= key_s1;
         sw_s1  <= bus.Sw;
         sw_s2  <= sw_s1;
      end
   end

   // A level is accepted only after it has differed from key_state for a full count.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_state   <= '1;
         key_state_d <= '1;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         key_state_d <= key_state;
         for (int i = 0; i < 4; i++) begin
            if (key_s2[i] == key_state[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
               key_state[i] <= key_s2[i];
               db_cnt[i]    <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign press = key_state_d & ~key_state;

   // hold_cnt saturates at the delay; rep_cnt then paces the periodic repeats.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < 2; j++) begin
            hold_cnt[j] <= '0;
            rep_cnt[j]  <= '0;
         end
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (key_state[j+2]) begin
               hold_cnt[j] <= '0;
               rep_cnt[j]  <= '0;
            end else if (hold_cnt[j] != HW'(REPEAT_DELAY)) begin
               hold_cnt[j] <= hold_cnt[j] + HW'(1);
            end else if (rep_cnt[j] == PW'(REPEAT_PERIOD - 1)) begin
               rep_cnt[j] <= '0;
            end else begin
               rep_cnt[j] <= rep_cnt[j] + PW'(1);
            end
         end
      end
   end

   always_comb begin
      rep = '0;
      for (int j = 0; j < 2; j++) begin
         rep[j] = !key_state[j+2] && (hold_cnt[j] == HW'(REPEAT_DELAY)) && (rep_cnt[j] == '0);
      end
   end

   assign ev = {press[3] | rep[1], press[2] | rep[0], press[1], press[0]};

   always_comb begin
      lsb      = {cursor, 2'b00};
      nib      = value[lsb +: 4];
      step     = 32'h1 << lsb;
      inc_val  = value;
      dec_val  = value;
      load_val = value;
      load_val[lsb +: 4] = sw_s2[3:0];
      if (sw_s2[6]) begin
         inc_val = value + step;
         dec_val = value - step;
      end else begin
         inc_val[lsb +: 4] = nib + 4'd1;
         dec_val[lsb +: 4] = nib - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value   <= INIT_VALUE;
         cursor  <= '0;
         changed <= 1'b0;
      end else begin
         changed <= |ev;
         if (ev[3]) begin
            value <= dec_val;
         end else if (ev[2]) begin
            value <= sw_s2[7] ? load_val : inc_val;
         end else if (ev[1]) begin
            cursor <= cursor + 3'd1;
         end else if (ev[0]) begin
            cursor <= cursor - 3'd1;
         end
      end
   end
endmodule

// File: doc/key_digit_editor.md
# key_digit_editor

Input-side companion to the 8-digit seven-segment display driver: it debounces the four board keys and, together with the switches, lets the user edit the 32-bit hex value that the display shows. It owns a digit cursor and the stored 32-bit value. The display driver reads `Value` as its stored number and `Cursor` to highlight the edited digit. Keys are active-low, like the display lines.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY`, default 25000000: hold time in cycles before auto-repeat starts (0.5 s).
- `REPEAT_PERIOD`, default 5000000: cycles between auto-repeat events (0.1 s).
- `INIT_VALUE`, default 32'h00000000: value loaded on reset.
- `clk` in 1: 50 MHz system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Key` in 4: raw buttons; 0 = pressed. Asynchronous to `clk`.
- `Sw` in 8: raw switches; `Sw[7]` = load mode, `Sw[6]` = carry mode, `Sw[3:0]` = load nibble. `Sw[5:4]` unused.
- `Value` out 32: edited value; digit i = `Value[4i+3:4i]`.
- `Cursor` out 3: selected digit index; 0 = least-significant nibble.
- `Changed` out 1: one-cycle pulse, high in the cycle after `Value` or `Cursor` updates.
- `KeyState` out 4: debounced key levels; 0 = pressed.

## Operation
- Synchronisers: `Key` and `Sw` each pass through a 2-flop synchroniser. The synchroniser flops reset to 1 for `Key` and to 0 for `Sw`.
- Debounce, per key: a counter clears whenever the synchronised level equals `KeyState[i]`. Otherwise it increments. When it reaches `DEBOUNCE_CYCLES`, `KeyState[i]` takes the new level and the counter clears. A glitch shorter than `DEBOUNCE_CYCLES` produces no change.
- Press event: a `KeyState[i]` 1→0 transition. Releases produce no event.
- Auto-repeat, Key[2] and Key[3] only:
  - While the key stays debounced-pressed, a hold counter runs from the press.
  - The first repeat event fires at `REPEAT_DELAY` cycles after the press, then one every `REPEAT_PERIOD` cycles.
  - Release clears the hold counter.
- Actions, one per cycle:
  - Key[0] press: Cursor ← Cursor−1, mod 8 (right).
  - Key[1] press: Cursor ← Cursor+1, mod 8 (left).
  - Key[2] event with Sw[7]=1: digit[Cursor] ← Sw[3:0].
  - Key[2] event with Sw[7]=0: increment.
  - Key[3] event: decrement. Sw[7] is ignored for Key[3].
- Increment/decrement arithmetic:
  - Sw[6]=0: nibble-local; only digit[Cursor] changes, wrapping F→0 / 0→F.
  - Sw[6]=1: full-width; Value ← Value ± (1 << 4·Cursor), mod 2^32, so carry and borrow propagate into higher digits.
- Simultaneous events in one cycle: priority Key[3] > Key[2] > Key[1] > Key[0]. Lower-priority events in that cycle are discarded, not queued.
- `Changed` pulses for every executed action, including a load that writes the same nibble value.

## Timing
- Reset values:
  - `Value` = INIT_VALUE, `Cursor` = 0, `Changed` = 0, `KeyState` = 4'hF.
  - All debounce and hold counters = 0.
- `rst` asserted mid-debounce or mid-hold discards all pending state. After reset, a key already held low still needs `DEBOUNCE_CYCLES` stable cycles and then generates one press event.
- Latency with a clean edge, where raw `Key[i]` is sampled low first at edge t:
  - `KeyState[i]` falls at edge t+2+DEBOUNCE_CYCLES.
  - `Value`/`Cursor` update at the following edge.
  - `Changed` is high for exactly that one cycle.
- Switch values are the synchronised values in the action cycle. `Sw` changes take effect 2 cycles later.
- Auto-repeat: with a continuous hold, repeat events occur at press+REPEAT_DELAY+k·REPEAT_PERIOD for k = 0, 1, 2, …
- Counters saturate rather than wrap; no spurious event on overflow.

## Test plan
(Benches use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.)
- Reset with INIT_VALUE=32'h0A1B2C3D → `Value`=0A1B2C3D, `Cursor`=0, `KeyState`=F, `Changed`=0. Reset mid-press → no event until the key is re-debounced.
- Key[2] low for 3 cycles then high (glitch) → `KeyState` and `Value` unchanged. Key[2] low and held → `Value` LSB nibble D→E, exactly one `Changed` pulse, at the edge given under Timing.
- Cursor wrap: Key[0] press at Cursor=0 → Cursor=7. Key[1] press at 7 → 0.
- Carry mode, Value=0000FFFF:
  - Cursor=0, Sw[6]=1, Key[2] → 00010000.
  - Same with Sw[6]=0 → 0000FFF0.
  - Key[3] at Value=00000000, Sw[6]=1 → FFFFFFFF.
- Load: Sw[7]=1, Sw[3:0]=9, Cursor=5, Key[2] → digit 5 = 9, others unchanged. Key[3] in load mode still decrements.
- Hold Key[3] for 60 cycles after debounce (nibble mode) → 1 press event + repeats at +20, +28, +36, +44, +52 = 6 decrements. Key[0] and Key[3] pressed in the same cycle → only the decrement happens and `Cursor` is unchanged.
